// File: rtl/nf10_axis_sim_arbiter.sv
// nf10_axis_sim_arbiter: packet-granular round-robin merge of four AXIS slaves (s_axis_0..3) onto one registered AXIS master (m_axis), reporting granted port (cur_port), busy and forwarded packet count (pkt_count); clock aclk, sync active-high reset
module nf10_axis_sim_arbiter #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
  input  logic                              aclk,
  input  logic                              reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_0_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_0_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_0_tuser,
  input  logic                              s_axis_0_tvalid,
  input  logic                              s_axis_0_tlast,
  output logic                              s_axis_0_tready,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_1_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_1_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_1_tuser,
  input  logic                              s_axis_1_tvalid,
  input  logic                              s_axis_1_tlast,
  output logic                              s_axis_1_tready,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_2_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_2_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_2_tuser,
  input  logic                              s_axis_2_tvalid,
  input  logic                              s_axis_2_tlast,
  output logic                              s_axis_2_tready,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_3_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_3_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_3_tuser,
  input  logic                              s_axis_3_tvalid,
  input  logic                              s_axis_3_tlast,
  output logic                              s_axis_3_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [1:0]                        cur_port,
  output logic                              busy,
  output logic [7:0]                        pkt_count
);
  typedef enum logic {IDLE, PKT} state_t;
  state_t state;
  logic [1:0] last, start, off, win;
  logic [3:0] req, rot;
  logic grant, accept, sel_valid, sel_last;
  logic [C_S_AXIS_DATA_WIDTH-1:0] sel_data;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0] sel_strb;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] sel_user;
  assign req = {s_axis_3_tvalid, s_axis_2_tvalid, s_axis_1_tvalid, s_axis_0_tvalid};
  assign start = last + 2'd1;
  assign rot = start == 2'd0 ? req :
               start == 2'd1 ? {req[0], req[3:1]} :
               start == 2'd2 ? {req[1:0], req[3:2]} : {req[2:0], req[3]};
  assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  assign win = start + off;
  assign sel_valid = cur_port == 2'd0 ? s_axis_0_tvalid : cur_port == 2'd1 ? s_axis_1_tvalid :
                     cur_port == 2'd2 ? s_axis_2_tvalid : s_axis_3_tvalid;
  assign sel_last  = cur_port == 2'd0 ? s_axis_0_tlast : cur_port == 2'd1 ? s_axis_1_tlast :
                     cur_port == 2'd2 ? s_axis_2_tlast : s_axis_3_tlast;
  assign sel_data  = cur_port == 2'd0 ? s_axis_0_tdata : cur_port == 2'd1 ? s_axis_1_tdata :
                     cur_port == 2'd2 ? s_axis_2_tdata : s_axis_3_tdata;
  assign sel_strb  = cur_port == 2'd0 ? s_axis_0_tstrb : cur_port == 2'd1 ? s_axis_1_tstrb :
                     cur_port == 2'd2 ? s_axis_2_tstrb : s_axis_3_tstrb;
  assign sel_user  = cur_port == 2'd0 ? s_axis_0_tuser : cur_port == 2'd1 ? s_axis_1_tuser :
                     cur_port == 2'd2 ? s_axis_2_tuser : s_axis_3_tuser;
  assign grant = state == PKT && (!m_axis_tvalid || m_axis_tready);
  assign accept = grant && sel_valid;
  assign s_axis_0_tready = grant && cur_port == 2'd0;
  assign s_axis_1_tready = grant && cur_port == 2'd1;
  assign s_axis_2_tready = grant && cur_port == 2'd2;
  assign s_axis_3_tready = grant && cur_port == 2'd3;
  assign busy = state == PKT;
  always_ff @(posedge aclk) begin
    if (reset) begin
      state <= IDLE;
      last <= 2'd3;
      cur_port <= 2'd0;
      m_axis_tdata <= '0;
      m_axis_tstrb <= '0;
      m_axis_tuser <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast <= 1'b0;
      pkt_count <= 8'd0;
    end else begin
      if (accept) begin
        m_axis_tdata <= sel_data;
        m_axis_tstrb <= sel_strb;
        m_axis_tuser <= sel_user;
        m_axis_tlast <= sel_last;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) pkt_count <= pkt_count + 8'd1;
      if (state == IDLE && |req) begin
        cur_port <= win;
        state <= PKT;
      end
      if (accept && sel_last) begin
        state <= IDLE;
        last <= cur_port;
      end
    end
  end
endmodule

// File: doc/nf10_axis_sim_arbiter.md
# nf10_axis_sim_arbiter

Packet-granular round-robin arbiter that merges four AXI Stream sources onto one AXI Stream master, for simulation benches that feed several stimulus or DUT ports into a single stream recorder. It grants whole packets and never interleaves beats from different sources. It also registers the output beat and reports which port owns the stream and how many packets have been forwarded.

## Interface
Parameters:
- C_S_AXIS_DATA_WIDTH, 256, tdata width for all ports; tstrb width is C_S_AXIS_DATA_WIDTH/8.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width for all ports.

Ports:
- aclk  in  1  sole clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- s_axis_N_tdata / _tstrb / _tuser  in  per parameters  slave beat for N = 0..3.
- s_axis_N_tvalid  in  1  slave N beat valid.
- s_axis_N_tlast  in  1  slave N last beat of packet.
- s_axis_N_tready  out  1  slave N beat accepted when high together with tvalid.
- m_axis_tdata / _tstrb / _tuser  out  per parameters  registered output beat.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tlast  out  1  output last beat.
- m_axis_tready  in  1  downstream accept.
- cur_port  out  2  index of the port currently granted; meaningful only while busy=1.
- busy  out  1  high while in state PKT.
- pkt_count  out  8  number of tlast beats forwarded to the master; wraps 255→0.

## Operation
- State machine with two states: IDLE and PKT.
- **IDLE:**
  - All s_axis_N_tready are 0.
  - Search for a requester (tvalid=1) starting at port (last+1) mod 4, where `last` is the last granted port.
  - If one is found, at the next edge: cur_port ← winner, state ← PKT, busy ← 1.
  - If none is found, remain in IDLE.
- **PKT:**
  - s_axis_N_tready = (N == cur_port) & (~m_axis_tvalid | m_axis_tready).
  - s_axis_N_tready is combinational from registered state and m_axis_tready.
  - All other ports see tready=0.
- **Output register update**, on an accepted beat (tvalid & tready on the granted port):
  - m_axis_tdata, tstrb, tuser and tlast ← slave values.
  - m_axis_tvalid ← 1.
  - Data, tstrb and tuser pass through unmodified.
- **Output register drain:** if m_axis_tvalid & m_axis_tready and no new beat is accepted, m_axis_tvalid ← 0.
- **Packet end:** an accepted beat with tlast=1 sets state ← IDLE, busy ← 0, last ← cur_port.
- **pkt_count** increments by 1 when m_axis_tvalid & m_axis_tready & m_axis_tlast. It is 8-bit modular.
- **Priority:** round-robin fairness is per packet, not per beat. A granted source keeps the grant through tvalid gaps mid-packet.
- **Upstream gaps:** a mid-packet tvalid=0 holds PKT. No beat is emitted, and m_axis_tvalid drops once the held beat drains.

## Timing
- **Reset values:**
  - state = IDLE, last = 3 (so port 0 has first priority), cur_port = 0.
  - busy = 0, m_axis_tvalid = 0, m_axis_tlast = 0.
  - m_axis_tdata, tstrb and tuser = 0; pkt_count = 0; all s_axis_N_tready = 0.
- **Reset mid-packet:**
  - Applies immediately at the edge.
  - Any held output beat is discarded (tvalid = 0).
  - The partially transferred packet is not completed; the source is expected to be reset too.
- **Latency from IDLE:**
  - tvalid rises at cycle 0.
  - The grant is registered at edge 0→1, and tready is high in cycle 1.
  - The beat is accepted at edge 1→2, and m_axis_tvalid=1 in cycle 2.
- **Throughput:**
  - One beat per cycle within a packet while m_axis_tready=1.
  - Exactly one dead (IDLE) cycle between consecutive packets, from the same or different ports.
- **Backpressure:**
  - With m_axis_tready=0 and m_axis_tvalid=1, the granted tready is 0.
  - The output beat and its data are held stable until accepted.
- **Single-beat packet** (tvalid & tlast at once): returns to IDLE after one PKT cycle.
- **Simultaneous requests in IDLE:** exactly one winner per the rotating order. A losing tvalid must be held by the source (AXI rule) and is never dropped.

## Test plan
- **Single port:** reset, then port 0 sends a 3-beat packet (tdata 0x1, 0x2, 0x3) with m_axis_tready=1.
  - m_axis shows 0x1 to 0x3 in cycles 2 to 4, with tlast on 0x3.
  - pkt_count=1; busy returns to 0.
- **Fairness:** all four ports continuously offer 2-beat packets.
  - Grant order is 0,1,2,3,0,1…
  - One idle cycle between packets; no beat interleaving.
  - pkt_count=8 after 8 packets.
- **Backpressure:** m_axis_tready toggles 1,0,0,1 during a 4-beat packet on port 2.
  - Output data is unchanged while stalled.
  - s_axis_2_tready=0 whenever the register is full and not draining.
  - All 4 beats arrive in order.
- **Mid-packet gap:** port 1 deasserts tvalid for 3 cycles mid-packet while port 3 requests.
  - cur_port stays 1 until tlast; port 3 is granted next.
- **Wrap:** 256 single-beat packets from port 0 give pkt_count=0. The 257th packet gives pkt_count=1.
- **Reset mid-packet:** assert reset during beat 2 of 5 on port 3.
  - Next cycle: m_axis_tvalid=0, busy=0, pkt_count=0.
  - A subsequent request on ports 0 and 3 together grants port 0 first.
